axis_cpu_ctl: RTL and testbench
===============================

AXIS_CPU_CTL -- requirements
Module: axis_cpu_ctl

Interface
REQ-001 Parameters SHALL be: NUM_CORES, default 4, number of CPU cores controlled (1..16); CODE_ADDR_WIDTH, default 10, program memory address width; DATA_WIDTH, default 32, register and debug width; NUM_REGS, default 16, registers dumped per core.
REQ-002 Ports SHALL be exactly as follows.
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-low reset.
- cmd_in_TDATA  in  32  command/data word.
- cmd_in_TVALID  in  1  word valid; no ready, and a word SHALL be accepted every valid cycle.
- cmd_out_TDATA  out  32  acknowledge word.
- cmd_out_TVALID  out  1  one-cycle acknowledge strobe.
- hold_in_rst  out  NUM_CORES  per-core reset hold.
- step_en  out  NUM_CORES  per-core instruction-fetch enable.
- prog_addr  out  CODE_ADDR_WIDTH  program write address.
- prog_data  out  32  program write data.
- prog_sel  out  1  target memory: 0 = instruction, 1 = immediate.
- prog_wr_en  out  NUM_CORES  one-hot write strobe.
- dbg_rd_addr  out  4  register index.
- dbg_rd_data  in  NUM_CORES*DATA_WIDTH  asynchronous register read, one slice per core.
- dbg_TDATA  out  DATA_WIDTH  debug stream data.
- dbg_TVALID  out  1  debug stream valid.
- dbg_TREADY  in  1  debug stream ready.
- dbg_TLAST  out  1  debug stream last beat.

Function
REQ-003 Command word fields SHALL be: [31:28] opcode, [27:24] core, [23:0] payload.
REQ-004 Opcodes SHALL be: 0 NOP; 1 HOLD (payload[0] sets hold_in_rst[core]); 2 STEP (payload[15:0] = N); 3 SETADDR; 4 WRINSTR; 5 WRIMM; 6 DUMP; 7 RUN (payload[0] sets free-run).
- Opcodes 8..15 SHALL be rejected with status BADOP.
- A core index >= NUM_CORES SHALL be rejected with status BADCORE, with no side effects.
REQ-005 The FSM SHALL have states IDLE, WDATA, STEP and DUMP.
- Commands SHALL be decoded only in IDLE.
- In WDATA, STEP or DUMP, any cmd_in word other than the WRINSTR/WRIMM data word SHALL be dropped with status BUSY.
REQ-006 SETADDR SHALL load the address register from payload[CODE_ADDR_WIDTH-1:0].
REQ-007 WRINSTR/WRIMM SHALL enter WDATA, and the next valid word SHALL become prog_data.
- On that word, prog_wr_en[core] SHALL pulse for exactly 1 cycle, with prog_addr and prog_sel stable in the same cycle.
- The address SHALL then increment modulo 2^CODE_ADDR_WIDTH, and the FSM SHALL return to IDLE.
REQ-008 STEP SHALL assert step_en[core] for exactly N consecutive cycles, then return to IDLE.
- N = 0 SHALL acknowledge OK immediately with no pulse.
- STEP on a held core SHALL return status HELD.
REQ-009 While RUN is set for a core, step_en[core] SHALL remain high in every cycle that its hold is clear.
- HOLD = 1 SHALL clear run.
- STEP on a running core SHALL return BUSY.
REQ-010 DUMP SHALL force step_en[core] low and stream NUM_REGS beats, register indices 0..NUM_REGS-1 in order.
- dbg_TLAST SHALL be high on the final beat only.
REQ-011 Debug output SHALL be registered.
- TDATA SHALL be loaded from the dbg_rd_data slice when the output is empty or accepted.
- TDATA, TVALID and TLAST SHALL stay stable while TVALID && !TREADY.
- Full throughput (1 beat/cycle) SHALL be sustained under constant TREADY.
REQ-012 Each command SHALL produce exactly one acknowledge on completion: {opcode, core, status[23:0]}.
- Status codes SHALL be: 0 OK, 1 BADCORE, 2 BADOP, 3 BUSY, 4 HELD.
- A BUSY acknowledge for a dropped word SHALL take priority over an in-flight completion and delay that completion by 1 cycle; no acknowledge SHALL be lost.
REQ-013 Acknowledge latency SHALL be 1 cycle after the accepting word for NOP, HOLD, SETADDR and RUN.
- For WRINSTR/WRIMM, the acknowledge SHALL come 1 cycle after the data word.
- For STEP and DUMP, the acknowledge SHALL come 1 cycle after the last pulse or last accepted beat.

Reset
REQ-014 Asserting rst SHALL immediately set all state as follows, including mid-command: FSM to IDLE; hold_in_rst to all ones; run, step_en, prog_wr_en, cmd_out_TVALID, dbg_TVALID and dbg_TLAST to 0; address, counters and data registers to 0.
REQ-015 Release of rst SHALL take effect on the first clk edge after deassertion; no command SHALL be accepted before that edge.

Structure
REQ-016 Opcode, status and state encodings SHALL live in a shared header, axis_cpu_ctl_defs.vh, as localparams.
REQ-017 The debug streaming path (index counter, output register, TLAST) SHALL be a sub-module, axis_cpu_dbg_dump.
REQ-018 The target size SHALL be 150-350 lines of RTL with no memories inferred.

Verification
REQ-019 HOLD core 2 = 0, SETADDR 0x3FF, WRINSTR data 0xAB -> prog_wr_en = 0100 at addr 0x3FF; the next write goes to addr 0x000; three OK acknowledges.
REQ-020 STEP core 1, N = 5, with hold clear -> step_en[1] high for exactly 5 cycles; acknowledge status 0 on the following cycle; STEP on a held core -> status 4.
REQ-021 DUMP core 0 with TREADY toggling 1010..., regs = index*3 -> 16 beats 0,3,...,45 with no duplicates or drops; TLAST on beat 16 only; data stable while stalled.
REQ-022 Command 0x9xxxxxxx -> BADOP; core 7 with NUM_CORES = 4 -> BADCORE; a NOP sent mid-DUMP -> BUSY acknowledge, with the dump completing intact.
REQ-023 rst asserted during STEP N = 100 at pulse 40 -> step_en falls immediately, hold_in_rst = 1111; after release, NOP is acknowledged OK.

Source files
------------

// File: rtl/axis_cpu_ctl_pkg.sv
// Shared encodings for the CPU control block: FSM states, opcodes, status codes
// and the acknowledge word layout.
package axis_cpu_ctl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WDATA = 2'd1,
    ST_STEP  = 2'd2,
    ST_DUMP  = 2'd3
  } state_t;

  localparam logic [3:0] OP_NOP     = 4'd0;
  localparam logic [3:0] OP_HOLD    = 4'd1;
  localparam logic [3:0] OP_STEP    = 4'd2;
  localparam logic [3:0] OP_SETADDR = 4'd3;
  localparam logic [3:0] OP_WRINSTR = 4'd4;
  localparam logic [3:0] OP_WRIMM   = 4'd5;
  localparam logic [3:0] OP_DUMP    = 4'd6;
  localparam logic [3:0] OP_RUN     = 4'd7;

  localparam logic [2:0] STS_OK      = 3'd0;
  localparam logic [2:0] STS_BADCORE = 3'd1;
  localparam logic [2:0] STS_BADOP   = 3'd2;
  localparam logic [2:0] STS_BUSY    = 3'd3;
  localparam logic [2:0] STS_HELD    = 3'd4;

  // Acknowledge word: {opcode, core, 24-bit status}.
  function automatic logic [31:0] ack_word(input logic [3:0] op, input logic [3:0] core,
                                           input logic [2:0] sts);
    return {op, core, 21'd0, sts};
  endfunction

endpackage

// File: rtl/axis_cpu_dbg_dump.sv
// Register dump streamer: walks register indices 0..NUM_REGS-1 and presents each
// value on a registered AXI-Stream style output with TLAST on the final beat.
module axis_cpu_dbg_dump #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic [3:0]            o_rd_addr,
  output logic [DATA_WIDTH-1:0] o_tdata,
  output logic                  o_tvalid,
  input  logic                  i_tready,
  output logic                  o_tlast,
  output logic                  o_done
);

  // Handshake: a beat transfers on a clock edge where o_tvalid && i_tready; while
  // o_tvalid is high and i_tready low, tdata/tvalid/tlast hold their values.
  localparam logic [4:0] LP_END = 5'(NUM_REGS);

  logic                  r_active;
  logic [4:0]            r_idx;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic                  r_tvalid;
  logic                  r_tlast;
  logic                  w_accept;
  logic                  w_load;

  assign w_accept  = r_tvalid & i_tready;
  assign w_load    = r_active & (r_idx != LP_END) & (~r_tvalid | i_tready);
  assign o_done    = w_accept & r_tlast;
  assign o_rd_addr = r_idx[3:0];
  assign o_tdata   = r_tdata;
  assign o_tvalid  = r_tvalid;
  assign o_tlast   = r_tlast;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_active <= 1'b0;
      r_idx    <= '0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_idx    <= '0;
    end else begin
      // Reloading on the accepting edge keeps one beat per cycle under steady ready.
      if (w_load) begin
        r_tdata  <= i_rd_data;
        r_tvalid <= 1'b1;
        r_tlast  <= (r_idx == LP_END - 5'd1);
        r_idx    <= r_idx + 5'd1;
      end else if (w_accept) begin
        r_tvalid <= 1'b0;
        r_tlast  <= 1'b0;
      end
      if (o_done) r_active <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_cpu_ctl.sv
// Command-stream controller for a cluster of CPU cores: reset hold, stepping,
// free-run, program memory writes and register dumps, one acknowledge per command.
module axis_cpu_ctl
  import axis_cpu_ctl_pkg::*;
#(
  parameter int NUM_CORES       = 4,
  parameter int CODE_ADDR_WIDTH = 10,
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_REGS        = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [31:0]                     cmd_in_TDATA,
  input  logic                            cmd_in_TVALID,
  output logic [31:0]                     cmd_out_TDATA,
  output logic                            cmd_out_TVALID,
  output logic [NUM_CORES-1:0]            hold_in_rst,
  output logic [NUM_CORES-1:0]            step_en,
  output logic [CODE_ADDR_WIDTH-1:0]      prog_addr,
  output logic [31:0]                     prog_data,
  output logic                            prog_sel,
  output logic [NUM_CORES-1:0]            prog_wr_en,
  output logic [3:0]                      dbg_rd_addr,
  input  logic [NUM_CORES*DATA_WIDTH-1:0] dbg_rd_data,
  output logic [DATA_WIDTH-1:0]           dbg_TDATA,
  output logic                            dbg_TVALID,
  input  logic                            dbg_TREADY,
  output logic                            dbg_TLAST
);

  localparam logic [4:0] LP_NC = 5'(NUM_CORES);

  state_t                     r_state, w_state_nx;
  logic [NUM_CORES-1:0]       r_hold, r_run, r_wr_en;
  logic [15:0]                r_step_cnt;
  logic [3:0]                 r_op, r_core;
  logic [CODE_ADDR_WIDTH-1:0] r_addr, r_prog_addr;
  logic [31:0]                r_prog_data;
  logic                       r_prog_sel;
  logic                       r_ack_v, r_pend_v;
  logic [31:0]                r_ack, r_pend;

  logic [3:0]                 w_op, w_core;
  logic                       w_core_ok;
  logic [NUM_CORES-1:0]       w_core_oh, w_rcore_oh;
  logic                       w_cmd_ld, w_hold_we, w_run_we, w_step_ld, w_addr_ld;
  logic                       w_wr_go, w_dump_start, w_sel_ld;
  logic                       w_comp_v, w_busy_v, w_dump_done;
  logic [31:0]                w_comp, w_busy;
  logic [DATA_WIDTH-1:0]      w_rd_slice;

  assign w_op      = cmd_in_TDATA[31:28];
  assign w_core    = cmd_in_TDATA[27:24];
  assign w_core_ok = ({1'b0, w_core} < LP_NC);
  assign w_busy_v  = cmd_in_TVALID & ((r_state == ST_STEP) | (r_state == ST_DUMP));
  assign w_busy    = ack_word(w_op, w_core, STS_BUSY);

  always_comb begin
    w_core_oh  = '0;
    w_rcore_oh = '0;
    w_rd_slice = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_core_oh[i]  = (w_core == 4'(i));
      w_rcore_oh[i] = (r_core == 4'(i));
      if (r_core == 4'(i)) w_rd_slice = dbg_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // A dump parks its core; otherwise a core runs free or is stepped by the FSM.
  always_comb begin
    step_en = r_run & ~r_hold;
    if (r_state == ST_STEP) step_en = step_en | w_rcore_oh;
    if (r_state == ST_DUMP) step_en = step_en & ~w_rcore_oh;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx   = r_state;
    w_cmd_ld     = 1'b0;
    w_hold_we    = 1'b0;
    w_run_we     = 1'b0;
    w_step_ld    = 1'b0;
    w_addr_ld    = 1'b0;
    w_wr_go      = 1'b0;
    w_dump_start = 1'b0;
    w_sel_ld     = 1'b0;
    w_comp_v     = 1'b0;
    w_comp       = ack_word(w_op, w_core, STS_OK);
    case (r_state)
      ST_IDLE: begin
        if (cmd_in_TVALID) begin
          w_comp_v = 1'b1;
          if (w_op[3]) begin
            w_comp = ack_word(w_op, w_core, STS_BADOP);
          end else if (!w_core_ok) begin
            w_comp = ack_word(w_op, w_core, STS_BADCORE);
          end else begin
            case (w_op)
              OP_NOP:     ;
              OP_HOLD:    w_hold_we = 1'b1;
              OP_STEP: begin
                if (|(r_hold & w_core_oh)) begin
                  w_comp = ack_word(w_op, w_core, STS_HELD);
                end else if (|(r_run & w_core_oh)) begin
                  w_comp = ack_word(w_op, w_core, STS_BUSY);
                end else if (cmd_in_TDATA[15:0] != 16'd0) begin
                  w_comp_v   = 1'b0;
                  w_step_ld  = 1'b1;
                  w_cmd_ld   = 1'b1;
                  w_state_nx = ST_STEP;
                end
              end
              OP_SETADDR: w_addr_ld = 1'b1;
              OP_WRINSTR, OP_WRIMM: begin
                w_comp_v   = 1'b0;
                w_cmd_ld   = 1'b1;
                w_sel_ld   = 1'b1;
                w_state_nx = ST_WDATA;
              end
              OP_DUMP: begin
                w_comp_v     = 1'b0;
                w_cmd_ld     = 1'b1;
                w_dump_start = 1'b1;
                w_state_nx   = ST_DUMP;
              end
              default:    w_run_we = 1'b1;
            endcase
          end
        end
      end
      ST_WDATA: begin
        if (cmd_in_TVALID) begin
          w_wr_go    = 1'b1;
          w_comp_v   = 1'b1;
          w_comp     = ack_word(r_op, r_core, STS_OK);
          w_state_nx = ST_IDLE;
        end
      end
      ST_STEP: begin
        if (r_step_cnt == 16'd1) begin
          w_comp_v   = 1'b1;
          w_comp     = ack_word(r_op, r_core, STS_OK);
          w_state_nx = ST_IDLE;
        end
      end
      default: begin
        if (w_dump_done) begin
          w_comp_v   = 1'b1;
          w_comp     = ack_word(r_op, r_core, STS_OK);
          w_state_nx = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold      <= '1;
      r_run       <= '0;
      r_wr_en     <= '0;
      r_step_cnt  <= '0;
      r_op        <= '0;
      r_core      <= '0;
      r_addr      <= '0;
      r_prog_addr <= '0;
      r_prog_data <= '0;
      r_prog_sel  <= 1'b0;
    end else begin
      r_wr_en <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (w_hold_we && w_core_oh[i]) begin
          r_hold[i] <= cmd_in_TDATA[0];
          if (cmd_in_TDATA[0]) r_run[i] <= 1'b0;
        end
        if (w_run_we && w_core_oh[i]) r_run[i] <= cmd_in_TDATA[0];
      end
      if (w_cmd_ld) begin
        r_op   <= w_op;
        r_core <= w_core;
      end
      if (w_sel_ld) r_prog_sel <= (w_op == OP_WRIMM);
      if (w_step_ld)                r_step_cnt <= cmd_in_TDATA[15:0];
      else if (r_state == ST_STEP)  r_step_cnt <= r_step_cnt - 16'd1;
      if (w_addr_ld) r_addr <= cmd_in_TDATA[CODE_ADDR_WIDTH-1:0];
      // prog_addr is a separate register so the strobe sees the pre-increment address.
      if (w_wr_go) begin
        r_prog_data <= cmd_in_TDATA;
        r_prog_addr <= r_addr;
        r_addr      <= r_addr + CODE_ADDR_WIDTH'(1);
        r_wr_en     <= w_rcore_oh;
      end
    end
  end

  // A BUSY ack for a dropped word wins the output; the displaced completion waits
  // one cycle in r_pend. Drops only occur in STEP/DUMP, so r_pend never overflows.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ack_v  <= 1'b0;
      r_ack    <= '0;
      r_pend_v <= 1'b0;
      r_pend   <= '0;
    end else if (w_busy_v) begin
      r_ack_v  <= 1'b1;
      r_ack    <= w_busy;
      r_pend_v <= w_comp_v;
      r_pend   <= w_comp;
    end else if (r_pend_v) begin
      r_ack_v  <= 1'b1;
      r_ack    <= r_pend;
      r_pend_v <= w_comp_v;
      r_pend   <= w_comp;
    end else begin
      r_ack_v  <= w_comp_v;
      r_pend_v <= 1'b0;
      if (w_comp_v) r_ack <= w_comp;
    end
  end

  axis_cpu_dbg_dump #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_dbg_dump (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_dump_start),
    .i_rd_data (w_rd_slice),
    .o_rd_addr (dbg_rd_addr),
    .o_tdata   (dbg_TDATA),
    .o_tvalid  (dbg_TVALID),
    .i_tready  (dbg_TREADY),
    .o_tlast   (dbg_TLAST),
    .o_done    (w_dump_done)
  );

  assign cmd_out_TDATA  = r_ack;
  assign cmd_out_TVALID = r_ack_v;
  assign hold_in_rst    = r_hold;
  assign prog_addr      = r_prog_addr;
  assign prog_data      = r_prog_data;
  assign prog_sel       = r_prog_sel;
  assign prog_wr_en     = r_wr_en;

endmodule

// File: tb/tb_axis_cpu_ctl.sv
// Directed bench for axis_cpu_ctl: writes, stepping, free-run, dumps, error
// statuses, BUSY priority and mid-command reset.
module tb_axis_cpu_ctl;

  logic         clk;
  logic         rst;
  logic [31:0]  cmd_in_TDATA;
  logic         cmd_in_TVALID;
  logic [31:0]  cmd_out_TDATA;
  logic         cmd_out_TVALID;
  logic [3:0]   hold_in_rst;
  logic [3:0]   step_en;
  logic [9:0]   prog_addr;
  logic [31:0]  prog_data;
  logic         prog_sel;
  logic [3:0]   prog_wr_en;
  logic [3:0]   dbg_rd_addr;
  logic [127:0] dbg_rd_data;
  logic [31:0]  dbg_TDATA;
  logic         dbg_TVALID;
  logic         dbg_TREADY;
  logic         dbg_TLAST;

  int total;
  int bad;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  axis_cpu_ctl dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_in_TDATA   (cmd_in_TDATA),
    .cmd_in_TVALID  (cmd_in_TVALID),
    .cmd_out_TDATA  (cmd_out_TDATA),
    .cmd_out_TVALID (cmd_out_TVALID),
    .hold_in_rst    (hold_in_rst),
    .step_en        (step_en),
    .prog_addr      (prog_addr),
    .prog_data      (prog_data),
    .prog_sel       (prog_sel),
    .prog_wr_en     (prog_wr_en),
    .dbg_rd_addr    (dbg_rd_addr),
    .dbg_rd_data    (dbg_rd_data),
    .dbg_TDATA      (dbg_TDATA),
    .dbg_TVALID     (dbg_TVALID),
    .dbg_TREADY     (dbg_TREADY),
    .dbg_TLAST      (dbg_TLAST)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file model: core c, register a holds a*3 + c*100.
  always_comb begin
    for (int c = 0; c < 4; c++) dbg_rd_data[c*32 +: 32] = 32'(dbg_rd_addr) * 32'd3 + 32'(c) * 32'd100;
  end

  always @(negedge clk) begin
    if (rst && cmd_out_TVALID) got_q.push_back(cmd_out_TDATA);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver: one valid word, returns 1 ns after the negedge following the accepting edge
  task automatic send(input logic [31:0] w);
    @(negedge clk);
    cmd_in_TDATA  = w;
    cmd_in_TVALID = 1'b1;
    @(negedge clk);
    cmd_in_TVALID = 1'b0;
    cmd_in_TDATA  = '0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; cmd_in_TVALID = 1'b0; cmd_in_TDATA = '0; dbg_TREADY = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++; if (hold_in_rst !== 4'hF) begin bad++; $display("FAIL reset_hold got=%h exp=f", hold_in_rst); end
    total++; if (step_en !== 4'h0) begin bad++; $display("FAIL reset_step got=%h exp=0", step_en); end
    total++; if ({cmd_out_TVALID, dbg_TVALID, dbg_TLAST, prog_wr_en} !== 7'd0) begin
      bad++; $display("FAIL reset_strobes got=%b exp=0", {cmd_out_TVALID, dbg_TVALID, dbg_TLAST, prog_wr_en}); end
    total++; if (prog_addr !== 10'd0) begin bad++; $display("FAIL reset_addr got=%h exp=0", prog_addr); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_write;
    send(32'h1200_0000); exp_q.push_back(32'h1200_0000);
    total++; if ({cmd_out_TVALID, cmd_out_TDATA} !== {1'b1, 32'h1200_0000}) begin
      bad++; $display("FAIL hold_ack got=%b/%h exp=1/12000000", cmd_out_TVALID, cmd_out_TDATA); end
    total++; if (hold_in_rst !== 4'b1011) begin bad++; $display("FAIL hold_core2 got=%b exp=1011", hold_in_rst); end
    send(32'h3000_03FF); exp_q.push_back(32'h3000_0000);
    total++; if ({cmd_out_TVALID, cmd_out_TDATA} !== {1'b1, 32'h3000_0000}) begin
      bad++; $display("FAIL setaddr_ack got=%b/%h exp=1/30000000", cmd_out_TVALID, cmd_out_TDATA); end
    send(32'h4200_0000);
    total++; if (cmd_out_TVALID !== 1'b0) begin bad++; $display("FAIL wrinstr_early_ack got=%b exp=0", cmd_out_TVALID); end
    send(32'h0000_00AB); exp_q.push_back(32'h4200_0000);
    total++; if ({prog_wr_en, prog_addr, prog_data, prog_sel} !== {4'b0100, 10'h3FF, 32'hAB, 1'b0}) begin
      bad++; $display("FAIL wr1 got=%b/%h/%h/%b exp=0100/3ff/ab/0", prog_wr_en, prog_addr, prog_data, prog_sel); end
    total++; if ({cmd_out_TVALID, cmd_out_TDATA} !== {1'b1, 32'h4200_0000}) begin
      bad++; $display("FAIL wr1_ack got=%b/%h exp=1/42000000", cmd_out_TVALID, cmd_out_TDATA); end
    @(negedge clk); #1;
    total++; if (prog_wr_en !== 4'b0000) begin bad++; $display("FAIL wr1_pulse_len got=%b exp=0000", prog_wr_en); end
    send(32'h5200_0000);
    send(32'h0000_00CD); exp_q.push_back(32'h5200_0000);
    total++; if ({prog_wr_en, prog_addr, prog_data, prog_sel} !== {4'b0100, 10'h000, 32'hCD, 1'b1}) begin
      bad++; $display("FAIL wr2_wrap got=%b/%h/%h/%b exp=0100/000/cd/1", prog_wr_en, prog_addr, prog_data, prog_sel); end
  endtask

  task automatic test_step;
    int cnt;
    int ack_k;
    logic [31:0] ack;
    send(32'h1100_0000); exp_q.push_back(32'h1100_0000);
    send(32'h2100_0005); exp_q.push_back(32'h2100_0000);
    cnt = 0; ack_k = -1; ack = '0;
    for (int k = 0; k < 20; k++) begin
      if (cmd_out_TVALID) begin ack_k = k; ack = cmd_out_TDATA; break; end
      if (step_en[1]) cnt++;
      @(negedge clk); #1;
    end
    total++; if (cnt !== 5) begin bad++; $display("FAIL step5_pulses got=%0d exp=5", cnt); end
    total++; if ({ack_k, ack} !== {32'd5, 32'h2100_0000}) begin
      bad++; $display("FAIL step5_ack got=k%0d/%h exp=k5/21000000", ack_k, ack); end
    total++; if (step_en !== 4'b0000) begin bad++; $display("FAIL step5_after got=%b exp=0000", step_en); end
    send(32'h2300_0005); exp_q.push_back(32'h2300_0004);
    total++; if ({cmd_out_TVALID, cmd_out_TDATA, step_en} !== {1'b1, 32'h2300_0004, 4'b0000}) begin
      bad++; $display("FAIL step_held got=%b/%h/%b exp=1/23000004/0000", cmd_out_TVALID, cmd_out_TDATA, step_en); end
    send(32'h2100_0000); exp_q.push_back(32'h2100_0000);
    total++; if ({cmd_out_TVALID, cmd_out_TDATA, step_en} !== {1'b1, 32'h2100_0000, 4'b0000}) begin
      bad++; $display("FAIL step_n0 got=%b/%h/%b exp=1/21000000/0000", cmd_out_TVALID, cmd_out_TDATA, step_en); end
  endtask

  task automatic test_run;
    send(32'h7100_0001); exp_q.push_back(32'h7100_0000);
    repeat (3) @(negedge clk);
    #1;
    total++; if (step_en !== 4'b0010) begin bad++; $display("FAIL run_high got=%b exp=0010", step_en); end
    send(32'h2100_0003); exp_q.push_back(32'h2100_0003);
    total++; if ({cmd_out_TVALID, cmd_out_TDATA} !== {1'b1, 32'h2100_0003}) begin
      bad++; $display("FAIL step_running got=%b/%h exp=1/21000003", cmd_out_TVALID, cmd_out_TDATA); end
    send(32'h1100_0001); exp_q.push_back(32'h1100_0000);
    total++; if (step_en !== 4'b0000) begin bad++; $display("FAIL run_hold got=%b exp=0000", step_en); end
    send(32'h1100_0000); exp_q.push_back(32'h1100_0000);
    @(negedge clk); #1;
    total++; if (step_en !== 4'b0000) begin bad++; $display("FAIL run_cleared got=%b exp=0000", step_en); end
  endtask

  task automatic test_dump_toggle;
    int beats;
    int last_k;
    int ack_k;
    logic [31:0] ack;
    logic stalled;
    logic [32:0] saved;
    dbg_TREADY = 1'b0;
    send(32'h6000_0000); exp_q.push_back(32'h6000_0000);
    beats = 0; last_k = -1; ack_k = -1; ack = '0; stalled = 1'b0; saved = '0;
    for (int k = 0; k < 50; k++) begin
      dbg_TREADY = (k % 2 == 0);
      if (cmd_out_TVALID && ack_k < 0) begin ack_k = k; ack = cmd_out_TDATA; end
      if (stalled) begin
        total++; if ({dbg_TVALID, dbg_TLAST, dbg_TDATA} !== {1'b1, saved}) begin
          bad++; $display("FAIL dump_stall_stable k=%0d got=%b/%b/%h exp=1/%h", k, dbg_TVALID, dbg_TLAST, dbg_TDATA, saved); end
      end
      stalled = dbg_TVALID && !dbg_TREADY;
      saved   = {dbg_TLAST, dbg_TDATA};
      if (dbg_TVALID && dbg_TREADY) begin
        total++; if ({dbg_TLAST, dbg_TDATA} !== {(beats == 15), 32'(beats * 3)}) begin
          bad++; $display("FAIL dump_beat%0d got=%b/%h exp=%b/%h", beats, dbg_TLAST, dbg_TDATA, (beats == 15), beats * 3); end
        beats++;
        last_k = k;
      end
      @(negedge clk); #1;
    end
    dbg_TREADY = 1'b1;
    total++; if (beats !== 16) begin bad++; $display("FAIL dump_count got=%0d exp=16", beats); end
    total++; if ({ack_k, ack} !== {last_k + 1, 32'h6000_0000}) begin
      bad++; $display("FAIL dump_ack got=k%0d/%h exp=k%0d/60000000", ack_k, ack, last_k + 1); end
  endtask

  task automatic test_back_to_back;
    int beats;
    int last_k;
    int n;
    logic [31:0] ack_w[3];
    int ack_c[3];
    dbg_TREADY = 1'b1;
    for (int i = 0; i < 3; i++) begin ack_w[i] = 'x; ack_c[i] = -1; end
    send(32'h6100_0000);
    exp_q.push_back(32'h0000_0003); exp_q.push_back(32'h0100_0003); exp_q.push_back(32'h6100_0000);
    beats = 0; last_k = -1; n = 0;
    for (int k = 0; k < 40; k++) begin
      if (cmd_out_TVALID) begin
        if (n < 3) begin ack_w[n] = cmd_out_TDATA; ack_c[n] = k; end
        n++;
      end
      if (dbg_TVALID && dbg_TREADY) begin
        total++; if (dbg_TDATA !== 32'(beats * 3 + 100)) begin
          bad++; $display("FAIL b2b_beat%0d got=%h exp=%h", beats, dbg_TDATA, beats * 3 + 100); end
        beats++;
        last_k = k;
      end
      cmd_in_TVALID = (k == 3 || k == 16);
      cmd_in_TDATA  = (k == 16) ? 32'h0100_0000 : 32'h0000_0000;
      @(negedge clk); #1;
    end
    cmd_in_TVALID = 1'b0;
    total++; if ({beats, last_k} !== {32'd16, 32'd16}) begin
      bad++; $display("FAIL b2b_throughput got=%0d beats,last k%0d exp=16,k16", beats, last_k); end
    total++; if (n !== 3) begin bad++; $display("FAIL b2b_ack_count got=%0d exp=3", n); end
    total++; if ({ack_w[0], ack_c[0]} !== {32'h0000_0003, 32'd4}) begin
      bad++; $display("FAIL busy_ack1 got=%h@%0d exp=00000003@4", ack_w[0], ack_c[0]); end
    total++; if ({ack_w[1], ack_c[1]} !== {32'h0100_0003, 32'd17}) begin
      bad++; $display("FAIL busy_ack2 got=%h@%0d exp=01000003@17", ack_w[1], ack_c[1]); end
    total++; if ({ack_w[2], ack_c[2]} !== {32'h6100_0000, 32'd18}) begin
      bad++; $display("FAIL dump_ack_delayed got=%h@%0d exp=61000000@18", ack_w[2], ack_c[2]); end
  endtask

  task automatic test_errors;
    send(32'h9300_0000); exp_q.push_back(32'h9300_0002);
    total++; if ({cmd_out_TVALID, cmd_out_TDATA} !== {1'b1, 32'h9300_0002}) begin
      bad++; $display("FAIL badop got=%b/%h exp=1/93000002", cmd_out_TVALID, cmd_out_TDATA); end
    send(32'h1700_0000); exp_q.push_back(32'h1700_0001);
    total++; if ({cmd_out_TVALID, cmd_out_TDATA, hold_in_rst} !== {1'b1, 32'h1700_0001, 4'b1001}) begin
      bad++; $display("FAIL badcore_hold got=%b/%h/%b exp=1/17000001/1001", cmd_out_TVALID, cmd_out_TDATA, hold_in_rst); end
    send(32'h4700_0000); exp_q.push_back(32'h4700_0001);
    total++; if ({cmd_out_TVALID, cmd_out_TDATA} !== {1'b1, 32'h4700_0001}) begin
      bad++; $display("FAIL badcore_wr got=%b/%h exp=1/47000001", cmd_out_TVALID, cmd_out_TDATA); end
    send(32'h0000_0000); exp_q.push_back(32'h0000_0000);
    total++; if ({cmd_out_TVALID, cmd_out_TDATA, prog_wr_en} !== {1'b1, 32'h0000_0000, 4'b0000}) begin
      bad++; $display("FAIL badcore_no_wdata got=%b/%h/%b exp=1/00000000/0000", cmd_out_TVALID, cmd_out_TDATA, prog_wr_en); end
  endtask

  task automatic test_reset_mid_step;
    send(32'h1000_0000); exp_q.push_back(32'h1000_0000);
    send(32'h2000_0064);
    repeat (39) @(negedge clk);
    #1;
    total++; if (step_en !== 4'b0001) begin bad++; $display("FAIL step100_pulse40 got=%b exp=0001", step_en); end
    #2 rst = 1'b0;
    #1;
    total++; if ({step_en, hold_in_rst, cmd_out_TVALID} !== {4'b0000, 4'b1111, 1'b0}) begin
      bad++; $display("FAIL mid_reset got=%b/%b/%b exp=0000/1111/0", step_en, hold_in_rst, cmd_out_TVALID); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    send(32'h0000_0000); exp_q.push_back(32'h0000_0000);
    total++; if ({cmd_out_TVALID, cmd_out_TDATA, step_en} !== {1'b1, 32'h0000_0000, 4'b0000}) begin
      bad++; $display("FAIL post_reset_nop got=%b/%h/%b exp=1/00000000/0000", cmd_out_TVALID, cmd_out_TDATA, step_en); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_write();
    test_step();
    test_run();
    test_dump_toggle();
    test_back_to_back();
    test_errors();
    test_reset_mid_step();
    repeat (2) @(negedge clk);
    // scoreboard: every acknowledge in order, none lost or extra
    total++; if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL ack_stream_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL ack_stream[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
